// File: rtl/feature_window_pkg.sv
// Shared defaults and derived sizes for the streaming K x K window generator.
package feature_window_pkg;
  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  // Index width that never collapses to zero bits for single-position axes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = idx_w(OUT_H);
  localparam int COL_W = idx_w(OUT_W);
endpackage

// File: rtl/feature_window_gen_line_buffer.sv
// One image row of delay: dout is the pixel shifted in DEPTH enables ago.
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk)
    if (en) mem <= {mem[DEPTH-2:0], din};

  assign dout = mem[DEPTH-1];
endmodule

// File: rtl/feature_window_gen.sv
// Streaming K x K window generator (stride 1, no padding) with valid/ready on both sides.
// Optional frame-length checking on in_last: define FEATURE_WINDOW_GEN_FRAME_CHECK_EN.
module feature_window_gen #(
  parameter int DATA_W = feature_window_pkg::DATA_W,
  parameter int IMG_W  = feature_window_pkg::IMG_W,
  parameter int IMG_H  = feature_window_pkg::IMG_H,
  parameter int K      = feature_window_pkg::K
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic [feature_window_pkg::idx_w(IMG_H-K+1)-1:0] win_row,
  output logic [feature_window_pkg::idx_w(IMG_W-K+1)-1:0] win_col,
  output logic                  win_last,
  output logic                  err
);
  import feature_window_pkg::*;

  localparam int RW  = idx_w(IMG_H - K + 1);
  localparam int CW  = idx_w(IMG_W - K + 1);
  localparam int RCW = idx_w(IMG_H);
  localparam int CCW = idx_w(IMG_W);

  localparam logic [RCW-1:0] ROW_LAST  = RCW'(IMG_H - 1);
  localparam logic [CCW-1:0] COL_LAST  = CCW'(IMG_W - 1);
  localparam logic [RCW-1:0] ROW_FIRST = RCW'(K - 1);
  localparam logic [CCW-1:0] COL_FIRST = CCW'(K - 1);

  logic [RCW-1:0] row;
  logic [CCW-1:0] col;
  logic           accept, term, bad, produce;

  logic [K-2:0][DATA_W-1:0]        lb_in, lb_out;
  logic [K-1:0][DATA_W-1:0]        column;
  logic [K-1:0][K-1:0][DATA_W-1:0] win;

  assign in_ready = rst && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign term     = (row == ROW_LAST) && (col == COL_LAST);

`ifdef FEATURE_WINDOW_GEN_FRAME_CHECK_EN
  assign bad = (in_last != term);
`else
  logic unused_last;
  assign unused_last = in_last;
  assign bad = 1'b0;
`endif

  assign produce = accept && !bad && (row >= ROW_FIRST) && (col >= COL_FIRST);

  // Buffer i feeds buffer i+1, so buffer K-2 holds the oldest row.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = in_data;
    end else begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
      .clk  (clk),
      .en   (accept),
      .din  (lb_in[i]),
      .dout (lb_out[i])
    );
  end

  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_new
      assign column[r] = in_data;
    end else begin : g_old
      assign column[r] = lb_out[K-2-r];
    end
  end

  assign win_data = win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      row       <= '0;
      col       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else begin
      if (accept) begin
        // Newest column enters on the right; c=0 is always the leftmost.
        for (int r = 0; r < K; r++)
          win[r] <= {column[r], win[r][K-1:1]};
        if (bad || term) begin
          row <= '0;
          col <= '0;
        end else if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (produce) begin
        win_valid <= 1'b1;
        win_row   <= RW'(row - ROW_FIRST);
        win_col   <= CW'(col - COL_FIRST);
        win_last  <= term;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef FEATURE_WINDOW_GEN_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst)              err <= 1'b0;
    else if (accept && bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_feature_window_gen.sv
// Self-checking bench: directed ramp/stall/reset sequences plus randomized traffic vs a sliding-window model.
module tb_feature_window_gen;
  localparam int DW = 8;

  logic           clk = 1'b0, rst = 1'b0;
  logic           in_valid = 1'b0, in_last = 1'b0, win_ready = 1'b1;
  logic [DW-1:0]  in_data = '0;
  logic           in_ready, win_valid, win_last, err;
  logic [71:0]    win_data;
  logic [2:0]     win_row, win_col;

  always #5 clk = ~clk;

  feature_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .K(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .win_row(win_row),
    .win_col(win_col), .win_last(win_last), .err(err)
  );

  int pass_cnt = 0, chk_cnt = 0;

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: remember the frame's pixels and cut windows from them.
  typedef struct packed {
    logic [71:0] d;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        l;
  } win_t;

  win_t        exp_q[$];
  logic [7:0]  img[64];
  int          pix_idx = 0, win_cnt = 0;
  logic [71:0] cap_d[36];
  logic        cap_l[36];
  logic        stall_seen = 1'b0;
  logic [79:0] snap;

  always @(negedge clk) begin
    win_t w;
    int   r, c, idx;
    bit   bad;
    if (!rst) begin
      pix_idx    = 0;
      stall_seen = 1'b0;
      exp_q.delete();
    end else begin
      check("in_ready_rule", {79'd0, in_ready}, {79'd0, !win_valid || win_ready});
      if (stall_seen)
        check("stall_hold", {win_valid, win_data, win_row, win_col, win_last}, snap);
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) check("win_spurious", 80'd1, 80'd0);
        else begin
          w = exp_q.pop_front();
          check("win", {1'b0, win_data, win_row, win_col, win_last}, {1'b0, w});
        end
        win_cnt++;
        idx = int'(win_row) * 6 + int'(win_col);
        if (idx < 36) begin
          cap_d[idx] = win_data;
          cap_l[idx] = win_last;
        end
      end
      if (in_valid && in_ready) begin
        bad = 1'b0;
`ifdef FEATURE_WINDOW_GEN_FRAME_CHECK_EN
        bad = (in_last != (pix_idx == 63));
`endif
        img[pix_idx] = in_data;
        if (bad) pix_idx = 0;
        else begin
          r = pix_idx / 8;
          c = pix_idx % 8;
          if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                w.d[(i*3+j)*8 +: 8] = img[(r-2+i)*8 + c-2+j];
            w.r = 3'(r - 2);
            w.c = 3'(c - 2);
            w.l = (r == 7 && c == 7);
            exp_q.push_back(w);
          end
          pix_idx = (pix_idx + 1) % 64;
        end
      end
      stall_seen = win_valid && !win_ready;
      snap       = {win_valid, win_data, win_row, win_col, win_last};
    end
  end

  // Consumer: always ready, random, or a one-shot 5-cycle hold at window (2,3).
  logic stall_arm = 1'b0, rand_rdy = 1'b0;
  int   stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      win_ready = 1'b0;
      stall_cnt--;
    end else if (stall_arm && win_valid && win_row == 3'd2 && win_col == 3'd3) begin
      win_ready = 1'b0;
      stall_cnt = 4;
      stall_arm = 1'b0;
    end else if (rand_rdy) win_ready = 1'($urandom_range(1));
    else win_ready = 1'b1;
  end

  int gap_pct = 0;

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 200) begin check("in_ready_timeout", 80'd0, 80'd1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic ramp(input int base);
    for (int i = 0; i < 64; i++) send(8'(base + i), i == 63);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || win_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_left", 80'(exp_q.size()), 80'd0);
  endtask

  typedef struct {
    int          phase;
    int          r;
    int          c;
    logic        l;
    logic [71:0] d;
  } vec_t;

  initial begin
    vec_t tbl[7];
    tbl[0] = '{0, 0, 0, 1'b0, 72'h121110_0A0908_020100};
    tbl[1] = '{0, 5, 5, 1'b1, 72'h3F3E3D_373635_2F2E2D};
    tbl[2] = '{0, 2, 3, 1'b0, 72'h252423_1D1C1B_151413};
    tbl[3] = '{0, 2, 4, 1'b0, 72'h262524_1E1D1C_161514};
    tbl[4] = '{0, 2, 5, 1'b0, 72'h272625_1F1E1D_171615};
    tbl[5] = '{1, 0, 0, 1'b0, 72'h767574_6E6D6C_666564};
    tbl[6] = '{1, 5, 5, 1'b1, 72'hA3A2A1_9B9A99_939291};

    repeat (2) @(posedge clk);
    #1;
    check("rst_win_data", {8'd0, win_data}, 80'd0);
    check("rst_flags", {72'd0, in_ready, win_valid, win_row, win_col, win_last, err}, 80'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single ramp with a 5-cycle consumer stall at (2,3).
    stall_arm = 1'b1;
    win_cnt = 0;
    ramp(0);
    drain();
    check("ramp_count", 80'(win_cnt), 80'd36);
    for (int k = 0; k < 7; k++)
      if (tbl[k].phase == 0) begin
        check($sformatf("tbl%0d_data", k), {8'd0, cap_d[tbl[k].r*6 + tbl[k].c]}, {8'd0, tbl[k].d});
        check($sformatf("tbl%0d_last", k), {79'd0, cap_l[tbl[k].r*6 + tbl[k].c]}, {79'd0, tbl[k].l});
      end

    // Back-to-back frames, second offset by 100.
    win_cnt = 0;
    ramp(0);
    ramp(100);
    drain();
    check("b2b_count", 80'(win_cnt), 80'd72);
    for (int k = 0; k < 7; k++)
      if (tbl[k].phase == 1) begin
        check($sformatf("tbl%0d_data", k), {8'd0, cap_d[tbl[k].r*6 + tbl[k].c]}, {8'd0, tbl[k].d});
        check($sformatf("tbl%0d_last", k), {79'd0, cap_l[tbl[k].r*6 + tbl[k].c]}, {79'd0, tbl[k].l});
      end

    // Reset in mid-frame after pixel 30.
    for (int i = 0; i <= 30; i++) send(8'(i), 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {79'd0, win_valid}, 80'd0);
    check("midrst_err", {79'd0, err}, 80'd0);
    check("midrst_in_ready", {79'd0, in_ready}, 80'd0);
    rst = 1'b1;
    win_cnt = 0;
    ramp(50);
    drain();
    check("midrst_count", 80'(win_cnt), 80'd36);

`ifdef FEATURE_WINDOW_GEN_FRAME_CHECK_EN
    for (int i = 0; i <= 40; i++) send(8'(i), i == 40);
    check("frame_err_set", {79'd0, err}, 80'd1);
    drain();
    win_cnt = 0;
    ramp(7);
    drain();
    check("frame_resync_count", 80'(win_cnt), 80'd36);
    check("frame_err_sticky", {79'd0, err}, 80'd1);
`else
    check("err_tied", {79'd0, err}, 80'd0);
`endif

    // Random handshakes on both sides over 10 frames.
    rand_rdy = 1'b1;
    gap_pct  = 50;
    win_cnt  = 0;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < 64; i++) send(8'($urandom_range(255)), i == 63);
    gap_pct = 0;
    drain();
    check("rand_count", 80'(win_cnt), 80'd360);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end
endmodule
